// File: rtl/mar_mdr_ctrl.sv
// MAR/MDR memory-access stage: latches EA or BUS into MAR and runs a fixed-wait SRAM access.
// Optional MAR_MDR_PROTO_ERR_EN compiles in the sticky PROTO_ERR flag.
module mar_mdr_ctrl #(
    parameter int unsigned WAIT_CYCLES = 32'd2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] EA,
    input  logic [15:0] BUS,
    input  logic        MARMUX_SEL,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] Data_to_SRAM,
    output logic        CE_N,
    output logic        OE_N,
    output logic        WE_N,
    output logic        BUSY,
    output logic        MEM_READY,
    output logic        PROTO_ERR
);
    if (WAIT_CYCLES > 32'd15) begin : g_wait_range
        $error("WAIT_CYCLES must be in 0..15");
    end

    localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e      state_r;
    logic [3:0]  cnt_r;
    logic        op_we_r;
    logic [15:0] mar_r;
    logic [15:0] mdr_r;
    logic        ce_n_r;
    logic        oe_n_r;
    logic        we_n_r;
    logic        busy_r;
    logic        mem_ready_r;

    // Access FSM with registered strobes; MAR/MDR only load while IDLE
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            op_we_r     <= 1'b0;
            mar_r       <= 16'h0000;
            mdr_r       <= 16'h0000;
            ce_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            we_n_r      <= 1'b1;
            busy_r      <= 1'b0;
            mem_ready_r <= 1'b0;
        end else begin
            mem_ready_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (LD_MAR) begin
                        mar_r <= MARMUX_SEL ? BUS : EA;
                    end
                    if (LD_MDR) begin
                        mdr_r <= BUS;
                    end
                    if (MEM_REQ) begin
                        op_we_r <= MEM_WE;
                        cnt_r   <= WAIT_LD;
                        state_r <= ACCESS;
                        ce_n_r  <= 1'b0;
                        oe_n_r  <= MEM_WE;
                        we_n_r  <= ~MEM_WE;
                        busy_r  <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_r == 4'd0) begin
                        if (!op_we_r) begin
                            mdr_r <= Data_from_SRAM;
                        end
                        state_r     <= DONE;
                        ce_n_r      <= 1'b1;
                        oe_n_r      <= 1'b1;
                        we_n_r      <= 1'b1;
                        mem_ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ce_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                    we_n_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAR_MDR_PROTO_ERR_EN
    logic proto_err_r;
    logic illegal_s;

    assign illegal_s = (state_r != IDLE) && (LD_MAR || LD_MDR || MEM_REQ);

    // Sticky flag for any load or request issued while busy
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            proto_err_r <= 1'b0;
        end else if (illegal_s) begin
            proto_err_r <= 1'b1;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign PROTO_ERR = proto_err_r;
`else
    assign PROTO_ERR = 1'b0;
`endif

    assign MAR          = mar_r;
    assign MDR          = mdr_r;
    assign Data_to_SRAM = mdr_r;
    assign CE_N         = ce_n_r;
    assign OE_N         = oe_n_r;
    assign WE_N         = we_n_r;
    assign BUSY         = busy_r;
    assign MEM_READY    = mem_ready_r;
endmodule

// File: tb/tb_mar_mdr_ctrl.sv
// Directed + randomized bench for mar_mdr_ctrl; two instances cover WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_mar_mdr_ctrl;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] EA;
    logic [15:0] BUS;
    logic        MARMUX_SEL;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [15:0] Data_from_SRAM;

    logic [15:0] mar_a, mdr_a, dts_a, mar_z, mdr_z, dts_z;
    logic        ce_a, oe_a, we_a, busy_a, rdy_a, perr_a;
    logic        ce_z, oe_z, we_z, busy_z, rdy_z, perr_z;

    always #5 Clk = ~Clk;

    mar_mdr_ctrl #(.WAIT_CYCLES(2)) dut_a (
        .Clk(Clk), .Reset(Reset), .EA(EA), .BUS(BUS), .MARMUX_SEL(MARMUX_SEL),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .Data_from_SRAM(Data_from_SRAM), .MAR(mar_a), .MDR(mdr_a), .Data_to_SRAM(dts_a),
        .CE_N(ce_a), .OE_N(oe_a), .WE_N(we_a), .BUSY(busy_a), .MEM_READY(rdy_a),
        .PROTO_ERR(perr_a)
    );

    mar_mdr_ctrl #(.WAIT_CYCLES(0)) dut_z (
        .Clk(Clk), .Reset(Reset), .EA(EA), .BUS(BUS), .MARMUX_SEL(MARMUX_SEL),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .Data_from_SRAM(Data_from_SRAM), .MAR(mar_z), .MDR(mdr_z), .Data_to_SRAM(dts_z),
        .CE_N(ce_z), .OE_N(oe_z), .WE_N(we_z), .BUSY(busy_z), .MEM_READY(rdy_z),
        .PROTO_ERR(perr_z)
    );

    // Observation mux: which instance the current checks look at
    logic        sel_z = 1'b0;
    logic [15:0] o_mar, o_mdr, o_dts;
    logic        o_ce, o_oe, o_we, o_busy, o_rdy, o_perr;
    assign o_mar  = sel_z ? mar_z  : mar_a;
    assign o_mdr  = sel_z ? mdr_z  : mdr_a;
    assign o_dts  = sel_z ? dts_z  : dts_a;
    assign o_ce   = sel_z ? ce_z   : ce_a;
    assign o_oe   = sel_z ? oe_z   : oe_a;
    assign o_we   = sel_z ? we_z   : we_a;
    assign o_busy = sel_z ? busy_z : busy_a;
    assign o_rdy  = sel_z ? rdy_z  : rdy_a;
    assign o_perr = sel_z ? perr_z : perr_a;

`ifdef MAR_MDR_PROTO_ERR_EN
    localparam logic PERR_ON = 1'b1;
`else
    localparam logic PERR_ON = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model: architectural MAR/MDR and error flag
    logic [15:0] exp_mar;
    logic [15:0] exp_mdr;
    logic        exp_perr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        exp_mar = 16'h0000;
        exp_mdr = 16'h0000;
        exp_perr = 1'b0;
    endtask

    task automatic load_mar(input logic sel, input logic [15:0] ea, input logic [15:0] bus);
        MARMUX_SEL = sel;
        EA = ea;
        BUS = bus;
        LD_MAR = 1'b1;
        tick();
        LD_MAR = 1'b0;
        exp_mar = sel ? bus : ea;
        chk("mar_load", o_mar, exp_mar);
    endtask

    task automatic load_mdr(input logic [15:0] bus);
        BUS = bus;
        LD_MDR = 1'b1;
        tick();
        LD_MDR = 1'b0;
        exp_mdr = bus;
        chk("mdr_load", o_mdr, exp_mdr);
        chk("dts_eq_mdr", o_dts, exp_mdr);
    endtask

    // One access of w wait states; inj>0 fires an illegal LD_MAR+MEM_REQ in that ACCESS cycle
    task automatic run_access(input int w, input logic we, input logic [15:0] rd, input int inj);
        MEM_REQ = 1'b1;
        MEM_WE = we;
        Data_from_SRAM = rd;
        tick();
        MEM_REQ = 1'b0;
        for (int c = 1; c <= w + 1; c++) begin
            chk1("acc_ce_n", o_ce, 1'b0);
            chk1("acc_oe_n", o_oe, we);
            chk1("acc_we_n", o_we, ~we);
            chk1("acc_busy", o_busy, 1'b1);
            chk1("acc_ready", o_rdy, 1'b0);
            chk("acc_addr", o_mar, exp_mar);
            chk("acc_wdata", o_dts, exp_mdr);
            if (c == inj) begin
                EA = 16'hAAAA;
                MARMUX_SEL = 1'b0;
                LD_MAR = 1'b1;
                MEM_REQ = 1'b1;
                exp_perr = PERR_ON;
            end
            tick();
            LD_MAR = 1'b0;
            MEM_REQ = 1'b0;
        end
        if (!we) exp_mdr = rd;
        chk1("done_ce_n", o_ce, 1'b1);
        chk1("done_oe_n", o_oe, 1'b1);
        chk1("done_we_n", o_we, 1'b1);
        chk1("done_busy", o_busy, 1'b1);
        chk1("done_ready", o_rdy, 1'b1);
        chk("done_mdr", o_mdr, exp_mdr);
        tick();
        chk1("post_ready", o_rdy, 1'b0);
        chk1("post_busy", o_busy, 1'b0);
        chk1("post_ce_n", o_ce, 1'b1);
        chk("post_mar", o_mar, exp_mar);
        chk1("post_perr", o_perr, exp_perr);
    endtask

    initial begin
        Reset = 1'b0;
        EA = 16'h0000;
        BUS = 16'h0000;
        MARMUX_SEL = 1'b0;
        LD_MAR = 1'b0;
        LD_MDR = 1'b0;
        MEM_REQ = 1'b0;
        MEM_WE = 1'b0;
        Data_from_SRAM = 16'h0000;

        // Reset state
        do_reset();
        chk("rst_mar", o_mar, 16'h0000);
        chk("rst_mdr", o_mdr, 16'h0000);
        chk1("rst_ce_n", o_ce, 1'b1);
        chk1("rst_oe_n", o_oe, 1'b1);
        chk1("rst_we_n", o_we, 1'b1);
        chk1("rst_busy", o_busy, 1'b0);
        chk1("rst_ready", o_rdy, 1'b0);
        chk1("rst_perr", o_perr, 1'b0);

        // Read from EA-loaded MAR
        load_mar(1'b0, 16'h3005, 16'h7777);
        run_access(2, 1'b0, 16'hBEEF, 0);

        // Write: MDR from BUS, MAR from BUS via MARMUX
        load_mdr(16'h1234);
        load_mar(1'b1, 16'h4444, 16'h00FF);
        run_access(2, 1'b1, 16'h5555, 0);
        chk("wr_addr", o_mar, 16'h00FF);
        chk("wr_data", o_dts, 16'h1234);

        // Illegal request/load in ACCESS cycle 2
        run_access(2, 1'b0, 16'hC0DE, 2);
        tick();
        chk1("busy_no_second", o_busy, 1'b0);
        chk1("busy_no_second_ce", o_ce, 1'b1);
        chk("busy_mar_kept", o_mar, 16'h00FF);

        // Reset held two cycles in the middle of a write
        MEM_REQ = 1'b1;
        MEM_WE = 1'b1;
        tick();
        MEM_REQ = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        chk1("midrst_ce_n", o_ce, 1'b1);
        chk1("midrst_we_n", o_we, 1'b1);
        chk("midrst_mar", o_mar, 16'h0000);
        chk("midrst_mdr", o_mdr, 16'h0000);
        chk1("midrst_ready", o_rdy, 1'b0);
        tick();
        Reset = 1'b1;
        exp_mar = 16'h0000;
        exp_mdr = 16'h0000;
        exp_perr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("midrst_no_ready", o_rdy, 1'b0);
            chk1("midrst_perr", o_perr, 1'b0);
        end

        // Zero wait states, back-to-back reads on the WAIT_CYCLES=0 instance
        sel_z = 1'b1;
        run_access(0, 1'b0, 16'h1111, 0);
        run_access(0, 1'b0, 16'h2222, 0);
        sel_z = 1'b0;
        do_reset();

        // Randomized transactions against the reference model
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: load_mar(1'b0, 16'($urandom), 16'($urandom));
                1: load_mar(1'b1, 16'($urandom), 16'($urandom));
                2: load_mdr(16'($urandom));
                default: run_access(2, 1'($urandom), 16'($urandom),
                                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            endcase
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
